// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scheduling unit.
//   - sb_cnt_w(): width of one scoreboard countdown counter
//   - hazard_ctrl_t: the four pipeline-register control bits
//   - CTRL_NONE / CTRL_STALL / CTRL_REDIRECT: the three legal control patterns
package hazard_pkg;

  typedef struct packed {
    logic if_id_flush;
    logic id_ex_flush;
    logic pc_freeze;
    logic if_id_freeze;
  } hazard_ctrl_t;

  localparam hazard_ctrl_t CTRL_NONE = '{
    if_id_flush: 1'b0, id_ex_flush: 1'b0, pc_freeze: 1'b0, if_id_freeze: 1'b0
  };

  // A stall holds PC and IF/ID and inserts a bubble into ID/EX.
  localparam hazard_ctrl_t CTRL_STALL = '{
    if_id_flush: 1'b0, id_ex_flush: 1'b1, pc_freeze: 1'b1, if_id_freeze: 1'b1
  };

  // A redirect squashes both the IF and ID instructions; PC must move on.
  localparam hazard_ctrl_t CTRL_REDIRECT = '{
    if_id_flush: 1'b1, id_ex_flush: 1'b1, pc_freeze: 1'b0, if_id_freeze: 1'b0
  };

  // Counter must hold the largest latency it can be loaded with.
  function automatic int sb_cnt_w(input int load_lat, input int mc_lat);
    int max_lat;
    max_lat = (load_lat > mc_lat) ? load_lat : mc_lat;
    return $clog2(max_lat + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   set_en/idx/val    load counter set_idx with set_val (wins over decrement)
//   rd_idx_a/b        two read ports, busy_a/b = counter nonzero
//   busy_mask         bit r set when counter r is nonzero
// Entry 0 is the hardwired-zero register and is held at zero permanently.
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = $clog2(NUM_REGS),
  parameter int SB_W     = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [REG_W-1:0]    set_idx,
  input  logic [SB_W-1:0]     set_val,
  input  logic [REG_W-1:0]    rd_idx_a,
  input  logic [REG_W-1:0]    rd_idx_b,
  output logic                busy_a,
  output logic                busy_b,
  output logic [NUM_REGS-1:0] busy_mask
);

  logic [SB_W-1:0] cnt_q [NUM_REGS];

  // NOTE: the counter array is control state, not data storage: every entry
  // must be reset so a reset discards all pending hazards.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (rst || r == 0) begin
        cnt_q[r] <= '0;
      end else if (set_en && set_idx == r[REG_W-1:0]) begin
        cnt_q[r] <= set_val;
      end else if (cnt_q[r] != '0) begin
        cnt_q[r] <= cnt_q[r] - 1'b1;
      end
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_mask[r] = (cnt_q[r] != '0);
    end
  end

  assign busy_a = busy_mask[rd_idx_a];
  assign busy_b = busy_mask[rd_idx_b];

endmodule

// File: rtl/hazard_sched_unit.sv
// Hazard scheduling unit beside the ID stage.
// Tracks variable-latency load and multi-cycle results in a countdown
// scoreboard, blocks a second multi-cycle op while the unit is occupied,
// and drives flush/freeze/bubble controls with zero latency.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   id_*                         decode fields of the instruction in ID
//   ex_redirect                  taken branch/jump resolved in EX
//   if_id_flush, id_ex_flush     squash / bubble controls
//   pc_freeze, if_id_freeze      hold controls
//   sb_busy                      per-register pending-result mask
//   stall_cycles                 saturating count of stall cycles
module hazard_sched_unit
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = $clog2(NUM_REGS),
  parameter int LOAD_LAT = 1,
  parameter int MC_LAT   = 4,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    id_rs1,
  input  logic [REG_W-1:0]    id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic [REG_W-1:0]    id_rd,
  input  logic                id_mem_read,
  input  logic                id_multicycle,
  input  logic                ex_redirect,
  output logic                if_id_flush,
  output logic                id_ex_flush,
  output logic                pc_freeze,
  output logic                if_id_freeze,
  output logic [NUM_REGS-1:0] sb_busy,
  output logic [CNT_W-1:0]    stall_cycles
);

  localparam int SB_W = sb_cnt_w(LOAD_LAT, MC_LAT);

  logic [SB_W-1:0]     mc_cnt_q, mc_cnt_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic                busy_rs1, busy_rs2;
  logic [NUM_REGS-1:0] busy_mask;
  logic                raw_hit, mc_block, stall, issue;
  logic                sb_set_en;
  logic [SB_W-1:0]     sb_set_val;
  hazard_ctrl_t        ctrl;

  hazard_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .REG_W    (REG_W),
    .SB_W     (SB_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en    (sb_set_en),
    .set_idx   (id_rd),
    .set_val   (sb_set_val),
    .rd_idx_a  (id_rs1),
    .rd_idx_b  (id_rs2),
    .busy_a    (busy_rs1),
    .busy_b    (busy_rs2),
    .busy_mask (busy_mask)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    raw_hit = (id_use_rs1 && id_rs1 != '0 && busy_rs1) ||
              (id_use_rs2 && id_rs2 != '0 && busy_rs2);
    // Only a second multi-cycle op contends for the unit.
    mc_block = id_multicycle && (mc_cnt_q != '0);
    stall    = id_valid && !ex_redirect && (raw_hit || mc_block);
    issue    = id_valid && !ex_redirect && !stall;

    // Redirect outranks stall: the stalled instruction is being squashed.
    ctrl = CTRL_NONE;
    if (ex_redirect) begin
      ctrl = CTRL_REDIRECT;
    end else if (stall) begin
      ctrl = CTRL_STALL;
    end

    sb_set_en  = issue && (id_rd != '0) && (id_mem_read || id_multicycle);
    sb_set_val = id_multicycle ? SB_W'(MC_LAT) : SB_W'(LOAD_LAT);

    mc_cnt_d = mc_cnt_q;
    if (issue && id_multicycle) begin
      mc_cnt_d = SB_W'(MC_LAT - 1);
    end else if (mc_cnt_q != '0) begin
      mc_cnt_d = mc_cnt_q - 1'b1;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      mc_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      mc_cnt_q    <= mc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Outputs are forced low for the whole time reset is held, including the
  // first reset cycle before the registers have cleared.
  assign if_id_flush  = !rst && ctrl.if_id_flush;
  assign id_ex_flush  = !rst && ctrl.id_ex_flush;
  assign pc_freeze    = !rst && ctrl.pc_freeze;
  assign if_id_freeze = !rst && ctrl.if_id_freeze;
  assign sb_busy      = rst ? '0 : busy_mask;
  assign stall_cycles = rst ? '0 : stall_cnt_q;

endmodule
